rf_writeback_arbiter: RTL
=========================

Name: rf_writeback_arbiter

Overview:
- Write side of the 16-bit processor's register file. It collects results from the ALU and load/memory paths and serialises them onto the single register-file write port (one write per clock).
- A small in-order queue absorbs cycles where both sources complete together.
- It offers a forwarding lookup for two read addresses, so the decode stage sees results that are still pending.
- It sits between the execute/memory stages and the register file.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- AW, 4, register address width (16 registers).
- DW, 16, data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_valid  in  1  load result valid this cycle.
- mem_addr  in  AW  destination register of the load.
- mem_data  in  DW  load data (MDR).
- alu_valid  in  1  ALU result valid this cycle.
- alu_addr  in  AW  destination register of the ALU result.
- alu_data  in  DW  ALU result.
- in_ready  out  1  both sources may present a result this cycle.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  AW  register-file write address (registered).
- rf_wdata  out  DW  register-file write data (registered).
- fwd_addr_a  in  AW  forwarding lookup address A.
- fwd_addr_b  in  AW  forwarding lookup address B.
- fwd_hit_a  out  1  a pending write to fwd_addr_a exists.
- fwd_data_a  out  DW  data of the youngest pending write to fwd_addr_a.
- fwd_hit_b  out  1  same as fwd_hit_a, for address B.
- fwd_data_b  out  DW  same as fwd_data_a, for address B.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - queue count = 0, rd/wr pointers = 0;
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0;
  - in_ready = 1; fwd_hit_a/b = 0.
  - Reset mid-operation discards all pending writes.
- Acceptance:
  - An input is accepted only when its valid is high and in_ready is high.
  - in_ready = (count <= DEPTH-2), combinational from registered count.
  - Valid asserted while in_ready = 0 is ignored; the producer holds the result.
- Register 0 filter: accepted results with addr == 0 are dropped at acceptance. They are never queued and never forwarded.
- Ordering: on a simultaneous accept, the load result is older than the ALU result. Writes reach the register file strictly in age order.
- Each rising edge, the output register loads the oldest available item, in priority order:
  1. queue head;
  2. accepted mem input;
  3. accepted alu input.
  - If an item is loaded: rf_we = 1, with that item's address and data.
  - If nothing is available: rf_we = 0; rf_waddr and rf_wdata hold their values.
  - Items not loaded are enqueued in age order.
  - Enqueue and dequeue in the same cycle are legal; count changes by (pushes − pop).
- Latency: a single result accepted at edge N with the queue empty drives rf_we high during cycle N+1 (the register file captures it at edge N+2). Each queued item adds one cycle.
- Throughput: one write per cycle sustained. A continuous dual issue fills the queue; in_ready then drops until it drains to DEPTH-2.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH; a full queue is unreachable while the in_ready rule holds.
- Forwarding (combinational):
  - Search space: the output register (when rf_we = 1), all valid queue entries, and the accepted inputs of the current cycle.
  - The youngest match wins; age order is alu input > mem input > queue tail … head > output register.
  - A lookup address of 0 never hits.
  - fwd_data is 0 when there is no hit.
- Same destination written twice: both writes are issued in order and the register file ends with the younger value. Forwarding returns the younger value immediately.

Decomposition:
- Shared package (processor-wide):
  - AW and DW constants;
  - REG_ZERO = 0;
  - wb_entry struct {addr[AW], data[DW]}.
- Sub-module wb_fifo: circular DEPTH-entry queue with push0/push1/pop, count, and parallel read of all entries for the forwarding search.
- The top level holds the priority selection, output register and forwarding comparators.

Test Plan:
- Reset while 3 entries are queued and rf_we = 1 → outputs immediately rf_we = 0, rf_waddr = 0, rf_wdata = 0, in_ready = 1, fwd_hit_a = 0; no write issues afterwards.
- alu_valid, addr 5, data 0x1234, queue empty, at edge N → rf_we = 1, rf_waddr = 5, rf_wdata = 0x1234 in cycle N+1 only; fwd_addr_a = 5 hits 0x1234 during cycles N and N+1.
- mem (addr 3, data 0xAAAA) and alu (addr 3, data 0x5555) in the same cycle → writes 0xAAAA then 0x5555 on consecutive cycles; fwd_addr_b = 3 returns 0x5555 while both are pending.
- Dual-issue to addrs 1–8 for 4 consecutive cycles → in_ready falls after count reaches 3; the producer holds; all 8 writes issue in order with none lost or duplicated.
- alu addr 0, data 0xFFFF, accepted → no rf_we pulse; fwd_addr_a = 0 reports fwd_hit_a = 0.
- Queue holds addr 7 (0x0001) and addr 7 (0x0002) → fwd returns 0x0002; after draining, the register file holds 0x0002.

Source files
------------

// File: rtl/rf_writeback_arbiter_pkg.sv
// Processor-wide write-back definitions.
//   AW, DW      : register address and data widths (16 x 16-bit register file)
//   REG_ZERO    : hard-wired zero register; writes to it are discarded
//   wb_entry_t  : one pending register-file write (address + data)
package rf_writeback_arbiter_pkg;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 16;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_writeback_arbiter_wb_fifo.sv
// In-order circular queue of pending register-file writes.
//   clk, rst   : clock, asynchronous active-high reset
//   push0/din0 : enqueue the older of up to two items this cycle
//   push1/din1 : enqueue the younger item (only together with push0)
//   pop        : dequeue the head
//   head       : oldest entry
//   count      : number of valid entries
//   rd_ptr     : index of the head inside entries
//   entries    : raw storage, for the forwarding search
module rf_writeback_arbiter_wb_fifo
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push0,
    input  wb_entry_t             din0,
    input  logic                  push1,
    input  wb_entry_t             din1,
    input  logic                  pop,
    output wb_entry_t             head,
    output logic [CW-1:0]         count,
    output logic [PW-1:0]         rd_ptr,
    output wb_entry_t [DEPTH-1:0] entries
);

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [PW-1:0]         rd_q;
    logic [PW-1:0]         wr_q;
    logic [CW-1:0]         cnt_q;
    logic [PW-1:0]         wr_next;

    // Second slot of a dual push; wraps naturally since DEPTH is a power of two.
    assign wr_next = wr_q + PW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push0) begin
                mem_q[wr_q] <= din0;
            end
            if (push1) begin
                mem_q[wr_next] <= din1;
            end
            wr_q <= wr_q + PW'(push0) + PW'(push1);
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    assign head    = mem_q[rd_q];
    assign count   = cnt_q;
    assign rd_ptr  = rd_q;
    assign entries = mem_q;

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file write-back arbiter: merges load and ALU results onto the single
// register-file write port in age order, with a pending-write forwarding lookup.
//   clk, rst                       : clock, asynchronous active-high reset
//   mem_valid/mem_addr/mem_data    : load result
//   alu_valid/alu_addr/alu_data    : ALU result (younger than a same-cycle load)
//   in_ready                       : both sources may present a result
//   rf_we/rf_waddr/rf_wdata        : registered register-file write port
//   fwd_addr_a/b                   : forwarding lookup addresses
//   fwd_hit_a/b, fwd_data_a/b      : youngest pending value for each lookup
// DEPTH must be a power of two, at least 2.
module rf_writeback_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = rf_writeback_arbiter_pkg::AW,
    parameter int unsigned DW    = rf_writeback_arbiter_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    output logic          in_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    input  logic [AW-1:0] fwd_addr_a,
    input  logic [AW-1:0] fwd_addr_b,
    output logic          fwd_hit_a,
    output logic [DW-1:0] fwd_data_a,
    output logic          fwd_hit_b,
    output logic [DW-1:0] fwd_data_b
);

    import rf_writeback_arbiter_pkg::*;

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0]         count;
    logic [PW-1:0]         rd_ptr;
    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;

    logic      mem_acc;
    logic      alu_acc;
    wb_entry_t mem_ent;
    wb_entry_t alu_ent;

    logic      push0;
    logic      push1;
    logic      pop;
    wb_entry_t din0;
    wb_entry_t din1;
    logic      load;
    wb_entry_t load_ent;

    // Two free slots guarantee a dual push fits even without a pop.
    assign in_ready = (count <= CW'(DEPTH - 2));

    // Writes to the zero register are dropped here, so they never queue or forward.
    assign mem_acc = mem_valid && in_ready && (mem_addr != REG_ZERO);
    assign alu_acc = alu_valid && in_ready && (alu_addr != REG_ZERO);

    assign mem_ent = '{addr: mem_addr, data: mem_data};
    assign alu_ent = '{addr: alu_addr, data: alu_data};

    // Oldest available item goes to the output register; the rest queue behind it.
    always_comb begin
        load     = 1'b1;
        load_ent = head;
        pop      = 1'b0;
        push0    = 1'b0;
        push1    = 1'b0;
        din0     = mem_ent;
        din1     = alu_ent;
        if (count != '0) begin
            pop   = 1'b1;
            push0 = mem_acc || alu_acc;
            push1 = mem_acc && alu_acc;
            din0  = mem_acc ? mem_ent : alu_ent;
        end else if (mem_acc) begin
            load_ent = mem_ent;
            push0    = alu_acc;
            din0     = alu_ent;
        end else if (alu_acc) begin
            load_ent = alu_ent;
        end else begin
            load = 1'b0;
        end
    end

    rf_writeback_arbiter_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push0   (push0),
        .din0    (din0),
        .push1   (push1),
        .din1    (din1),
        .pop     (pop),
        .head    (head),
        .count   (count),
        .rd_ptr  (rd_ptr),
        .entries (entries)
    );

    // Address and data hold when idle; only the enable drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= load;
            if (load) begin
                rf_waddr <= load_ent.addr;
                rf_wdata <= load_ent.data;
            end
        end
    end

    // Search from oldest to youngest so the last match (youngest) wins.
    for (genvar p = 0; p < 2; p++) begin : g_fwd
        logic [AW-1:0] addr;
        logic          hit;
        logic [DW-1:0] data;

        assign addr = (p == 0) ? fwd_addr_a : fwd_addr_b;

        always_comb begin
            hit  = 1'b0;
            data = '0;
            if (addr != REG_ZERO) begin
                if (rf_we && (rf_waddr == addr)) begin
                    hit  = 1'b1;
                    data = rf_wdata;
                end
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if ((CW'(i) < count) && (entries[rd_ptr + PW'(i)].addr == addr)) begin
                        hit  = 1'b1;
                        data = entries[rd_ptr + PW'(i)].data;
                    end
                end
                if (mem_acc && (mem_addr == addr)) begin
                    hit  = 1'b1;
                    data = mem_data;
                end
                if (alu_acc && (alu_addr == addr)) begin
                    hit  = 1'b1;
                    data = alu_data;
                end
            end
        end
    end

    assign fwd_hit_a  = g_fwd[0].hit;
    assign fwd_data_a = g_fwd[0].data;
    assign fwd_hit_b  = g_fwd[1].hit;
    assign fwd_data_b = g_fwd[1].data;

endmodule
